// File: rtl/ex_div_pkg.sv
// Shared types and constants for the EX-stage integer divider.
package ex_div_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Handshake levels seen on start_i and driven on ready_o.
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Default operand width and the {hi, lo} result bus width.
  localparam int DefDataW      = 32;
  localparam int DoubleRegBusW = 2 * DefDataW;

endpackage

// File: rtl/ex_div_if.sv
// Request/response bundle between the EX stage and the divider.
interface ex_div_if #(
  parameter int DATA_W = 32
) ();

  logic                  start_i;
  logic                  annul_i;
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  busy_o;

  // EX stage side: issues requests, consumes the result.
  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, busy_o
  );

  // Divider side.
  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o, busy_o
  );

endinterface

// File: rtl/ex_div_div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] trial;

  // Trial-subtract the divisor from the partial remainder extended by the
  // next dividend bit; keep the difference only when it does not go negative.
  always_comb begin
    trial = {rem_i, quo_i[DATA_W-1]} - {1'b0, dvs_i};
    if (!trial[DATA_W]) begin
      rem_o = trial[DATA_W-1:0];
      quo_o = {quo_i[DATA_W-2:0], 1'b1};
    end else begin
      rem_o = {rem_i[DATA_W-2:0], quo_i[DATA_W-1]};
      quo_o = {quo_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div.sv
// Multi-cycle signed/unsigned 32-bit divider for DIV/DIVU in the EX stage.
// Result is {remainder, quotient}; one quotient bit is produced per cycle.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int DATA_W = DefDataW,
  parameter int CNT_W  = 6
) (
  input  logic     clk,
  input  logic     rst,     // active-low, asynchronous
  ex_div_if.slave  div_if
);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [DATA_W-1:0]   step_rem, step_quo;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  // Two's complement negate; the most negative value maps onto itself,
  // which reads correctly as its unsigned magnitude.
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
    return ~x + 1'b1;
  endfunction

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Operand magnitudes and final sign correction of the unsigned result.
  always_comb begin
    a_neg   = div_if.signed_div_i & div_if.opdata1_i[DATA_W-1];
    b_neg   = div_if.signed_div_i & div_if.opdata2_i[DATA_W-1];
    abs_a   = a_neg ? negate(div_if.opdata1_i) : div_if.opdata1_i;
    abs_b   = b_neg ? negate(div_if.opdata2_i) : div_if.opdata2_i;
    quo_fix = qneg_q ? negate(quo_q) : quo_q;
    rem_fix = rneg_q ? negate(rem_q) : rem_q;
  end

  // Next-state, iteration datapath and result register control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (div_if.start_i == DivStart && !div_if.annul_i) begin
          // Operands are sampled on this edge only.
          rem_d  = '0;
          quo_d  = abs_a;
          dvs_d  = abs_b;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          state_d = (div_if.opdata2_i == '0) ? DivByZero : DivOn;
        end
      end

      DivByZero: begin
        if (div_if.annul_i) begin
          state_d = DivFree;
        end else begin
          result_d = '0;
          ready_d  = DivResultReady;
          state_d  = DivEnd;
        end
      end

      DivOn: begin
        if (div_if.annul_i) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
          state_d  = DivFree;
        end else if (cnt_q != CNT_W'(DATA_W)) begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = DivResultReady;
          state_d  = DivEnd;
        end
      end

      DivEnd: begin
        // Result held until EX drops its request; annul has no effect here.
        if (div_if.start_i == DivStop) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
          state_d  = DivFree;
        end
      end

      default: begin
        state_d = DivFree;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign div_if.result_o = result_q;
  assign div_if.ready_o  = ready_q;
  assign div_if.busy_o   = (state_q != DivFree);

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: stimulus pushes expected results, a monitor
// pops and compares on each rising ready_o.
module tb_ex_div;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_div_if #(.DATA_W(32)) div_if ();

  ex_div #(.DATA_W(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (div_if)
  );

  int          assert_cnt = 0;
  int          fail_cnt   = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];
  bit          ready_seen = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%h", nm, act);
    end
  endtask

  // Monitor: one comparison per result presentation.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    string       nm;
    if (div_if.ready_o && !ready_seen) begin
      ready_seen = 1'b1;
      if (exp_q.size() == 0) begin
        assert_cnt++;
        fail_cnt++;
        $display("FAIL unexpected_ready: got result 0x%h, expected no result", div_if.result_o);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, "_result"}, div_if.result_o, e);
      end
    end else if (!div_if.ready_o) begin
      ready_seen = 1'b0;
    end
  end

  // Issue a request just after a clock edge; the next edge accepts it.
  task automatic start_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input logic [63:0] exp, input string nm);
    @(posedge clk);
    #1;
    check({nm, "_idle_busy"}, 64'(div_if.busy_o), 64'd0);
    div_if.start_i      = 1'b1;
    div_if.annul_i      = 1'b0;
    div_if.signed_div_i = sgn;
    div_if.opdata1_i    = a;
    div_if.opdata2_i    = b;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // Count edges from acceptance until ready_o, checking busy_o throughout.
  task automatic wait_ready(input int lat, input string nm);
    int edges;
    bit busy_ok;
    bit done;
    edges   = 0;
    busy_ok = 1'b1;
    done    = 1'b0;
    while (!done && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (!div_if.busy_o) busy_ok = 1'b0;
      if (div_if.ready_o) done = 1'b1;
    end
    check({nm, "_latency"}, 64'(edges), 64'(lat));
    check({nm, "_busy_held"}, 64'(busy_ok), 64'd1);
  endtask

  // Release the request and confirm the result bus clears on the next edge.
  task automatic drop_start(input string nm);
    div_if.start_i = 1'b0;
    @(posedge clk);
    #1;
    check({nm, "_drop_ready"}, 64'(div_if.ready_o), 64'd0);
    check({nm, "_drop_result"}, div_if.result_o, 64'd0);
    check({nm, "_drop_busy"}, 64'(div_if.busy_o), 64'd0);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] exp, input int lat, input string nm);
    start_div(a, b, sgn, exp, nm);
    wait_ready(lat, nm);
    drop_start(nm);
  endtask

  initial begin
    div_if.start_i      = 1'b0;
    div_if.annul_i      = 1'b0;
    div_if.signed_div_i = 1'b0;
    div_if.opdata1_i    = '0;
    div_if.opdata2_i    = '0;

    // Reset state.
    #12;
    check("reset_ready", 64'(div_if.ready_o), 64'd0);
    check("reset_result", div_if.result_o, 64'd0);
    check("reset_busy", 64'(div_if.busy_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic unsigned and signed divides.
    run_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 34, "divu_100_7");
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 34, "div_m7_2");
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 34, "div_7_m2");
    run_div(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 64'hFFFFFFFE_0000000E, 34, "div_m100_m7");
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 34, "divu_max_1");
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, 34, "divu_min_max");

    // Divide by zero.
    run_div(32'd5, 32'd0, 1'b1, 64'd0, 2, "div_5_0");
    run_div(32'hDEADBEEF, 32'd0, 1'b0, 64'd0, 2, "divu_x_0");

    // start and annul together: request ignored.
    @(posedge clk);
    #1;
    div_if.start_i   = 1'b1;
    div_if.annul_i   = 1'b1;
    div_if.opdata1_i = 32'd5;
    div_if.opdata2_i = 32'd1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("start_annul_busy", 64'(div_if.busy_o), 64'd0);
    end
    div_if.start_i = 1'b0;
    div_if.annul_i = 1'b0;

    // Annul during iteration 10, then immediate restart with 9/3.
    @(posedge clk);
    #1;
    div_if.start_i      = 1'b1;
    div_if.signed_div_i = 1'b0;
    div_if.opdata1_i    = 32'd100;
    div_if.opdata2_i    = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    check("annul_busy_before", 64'(div_if.busy_o), 64'd1);
    div_if.annul_i = 1'b1;
    @(posedge clk);
    #1;
    div_if.annul_i = 1'b0;
    check("annul_busy_after", 64'(div_if.busy_o), 64'd0);
    check("annul_ready_after", 64'(div_if.ready_o), 64'd0);
    div_if.opdata1_i = 32'd9;
    div_if.opdata2_i = 32'd3;
    exp_q.push_back(64'h00000000_00000003);
    name_q.push_back("restart_9_3");
    wait_ready(34, "restart_9_3");
    drop_start("restart_9_3");

    // Hold start past ready while operands change: result must not move.
    start_div(32'd1000, 32'd33, 1'b0, 64'h0000000A_0000001E, "hold_1000_33");
    wait_ready(34, "hold_1000_33");
    for (int i = 0; i < 3; i++) begin
      div_if.opdata1_i    = 32'h12345678 + 32'(i);
      div_if.opdata2_i    = 32'd3 + 32'(i);
      div_if.signed_div_i = ~div_if.signed_div_i;
      div_if.annul_i      = (i == 1);
      @(posedge clk);
      #1;
      check("hold_result", div_if.result_o, 64'h0000000A_0000001E);
      check("hold_ready", 64'(div_if.ready_o), 64'd1);
    end
    div_if.annul_i = 1'b0;
    drop_start("hold_1000_33");

    // Asynchronous reset while a result is being held.
    start_div(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, "rst_end");
    wait_ready(34, "rst_end");
    #2;
    rst = 1'b0;
    #1;
    check("rst_end_ready", 64'(div_if.ready_o), 64'd0);
    check("rst_end_result", div_if.result_o, 64'd0);
    check("rst_end_busy", 64'(div_if.busy_o), 64'd0);
    div_if.start_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Asynchronous reset in the middle of iterating.
    start_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, "rst_on");
    repeat (5) @(posedge clk);
    #1;
    check("rst_on_busy_before", 64'(div_if.busy_o), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_on_busy", 64'(div_if.busy_o), 64'd0);
    check("rst_on_ready", 64'(div_if.ready_o), 64'd0);
    check("rst_on_result", div_if.result_o, 64'd0);
    div_if.start_i = 1'b0;
    exp_q.delete();
    name_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Signed overflow case after reset release.
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 34, "div_min_m1");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
